// File: rtl/wb_pkg.sv
// Shared definitions for the registered writeback source-select pipeline:
// default entry field widths, the constant-source value and the skid-buffer state encoding.
package wb_pkg;

  localparam int unsigned WB_WIDTH     = 32;
  localparam int unsigned WB_NUM_SRC   = 9;
  localparam int unsigned WB_SEL_W     = 4;
  localparam int unsigned WB_ADDR_W    = 5;
  localparam int unsigned WB_CONST_VAL = 227;

  // Occupancy of the M/S pair: ONE means only M holds an entry.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } wb_state_e;

endpackage

// File: rtl/wb_src_decode.sv
// Combinational writeback source decode: selector -> data, qualified write-enable and illegal flag.
module wb_src_decode
  import wb_pkg::*;
#(
  parameter int unsigned WIDTH     = WB_WIDTH,
  parameter int unsigned NUM_SRC   = WB_NUM_SRC,
  parameter int unsigned SEL_W     = WB_SEL_W,
  parameter int unsigned ADDR_W    = WB_ADDR_W,
  parameter int unsigned CONST_VAL = WB_CONST_VAL
) (
  input  logic [SEL_W-1:0]         sel,
  input  logic [NUM_SRC*WIDTH-1:0] data_in,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic                     wr_en,
  output logic [WIDTH-1:0]         data,
  output logic                     wen,
  output logic                     err
);

  localparam logic [WIDTH-1:0] CONST_W = WIDTH'(CONST_VAL);

  logic legal;

  assign legal = (32'(sel) <= NUM_SRC);

  // Illegal selectors fall through to zero data rather than holding a previous value.
  always_comb begin
    data = '0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      if (32'(sel) == i) data = data_in[i*WIDTH +: WIDTH];
    end
    if (32'(sel) == NUM_SRC) data = CONST_W;
  end

  assign wen = wr_en && (wr_addr != '0) && legal;
  assign err = !legal;

endmodule

// File: rtl/wb_src_select_pipe.sv
// Registered writeback source mux with valid/ready handshake and a 2-entry skid buffer (M drives out_*).
module wb_src_select_pipe
  import wb_pkg::*;
#(
  parameter int unsigned WIDTH     = WB_WIDTH,
  parameter int unsigned NUM_SRC   = WB_NUM_SRC,
  parameter int unsigned SEL_W     = WB_SEL_W,
  parameter int unsigned ADDR_W    = WB_ADDR_W,
  parameter int unsigned CONST_VAL = WB_CONST_VAL
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [SEL_W-1:0]         sel,
  input  logic [NUM_SRC*WIDTH-1:0] data_in,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic                     wr_en,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_data,
  output logic [ADDR_W-1:0]        out_addr,
  output logic                     out_wen,
  output logic                     out_err,
  output logic                     err_sticky,
  input  logic                     err_clr
);

  wb_state_e state, state_nxt;

  logic [WIDTH-1:0]  dec_data;
  logic              dec_wen;
  logic              dec_err;

  logic [WIDTH-1:0]  m_data, s_data;
  logic [ADDR_W-1:0] m_addr, s_addr;
  logic              m_wen, s_wen;
  logic              m_err, s_err;

  logic in_xfer, out_xfer;
  logic load_m_in, load_m_s, load_s;

  wb_src_decode #(
    .WIDTH     (WIDTH),
    .NUM_SRC   (NUM_SRC),
    .SEL_W     (SEL_W),
    .ADDR_W    (ADDR_W),
    .CONST_VAL (CONST_VAL)
  ) u_decode (
    .sel     (sel),
    .data_in (data_in),
    .wr_addr (wr_addr),
    .wr_en   (wr_en),
    .data    (dec_data),
    .wen     (dec_wen),
    .err     (dec_err)
  );

  assign out_valid = (state != ST_EMPTY);
  assign in_xfer   = in_valid && in_ready;
  assign out_xfer  = out_valid && out_ready;

  assign out_data = m_data;
  assign out_addr = m_addr;
  assign out_wen  = m_wen;
  assign out_err  = m_err;

  always_comb begin
    state_nxt = state;
    load_m_in = 1'b0;
    load_m_s  = 1'b0;
    load_s    = 1'b0;
    case (state)
      ST_EMPTY: begin
        if (in_xfer) begin
          state_nxt = ST_ONE;
          load_m_in = 1'b1;
        end
      end
      ST_ONE: begin
        if (in_xfer && out_xfer) begin
          load_m_in = 1'b1;
        end else if (in_xfer) begin
          state_nxt = ST_TWO;
          load_s    = 1'b1;
        end else if (out_xfer) begin
          state_nxt = ST_EMPTY;
        end
      end
      ST_TWO: begin
        // in_ready is low here, so only the drain of M needs handling.
        if (out_xfer) begin
          state_nxt = ST_ONE;
          load_m_s  = 1'b1;
        end
      end
      default: state_nxt = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_EMPTY;
      in_ready   <= 1'b1;
      m_data     <= '0;
      m_addr     <= '0;
      m_wen      <= 1'b0;
      m_err      <= 1'b0;
      s_data     <= '0;
      s_addr     <= '0;
      s_wen      <= 1'b0;
      s_err      <= 1'b0;
      err_sticky <= 1'b0;
    end else begin
      state    <= state_nxt;
      in_ready <= (state_nxt != ST_TWO);
      if (load_m_in) begin
        m_data <= dec_data;
        m_addr <= wr_addr;
        m_wen  <= dec_wen;
        m_err  <= dec_err;
      end else if (load_m_s) begin
        m_data <= s_data;
        m_addr <= s_addr;
        m_wen  <= s_wen;
        m_err  <= s_err;
      end
      if (load_s) begin
        s_data <= dec_data;
        s_addr <= wr_addr;
        s_wen  <= dec_wen;
        s_err  <= dec_err;
      end
      if (in_xfer && dec_err) err_sticky <= 1'b1;
      else if (err_clr)       err_sticky <= 1'b0;
    end
  end

endmodule

// File: tb/tb_wb_src_select_pipe.sv
// Scoreboard bench for wb_src_select_pipe: expected entries queued on input transfer, checked on output transfer.
module tb_wb_src_select_pipe;

  localparam int unsigned W  = 32;
  localparam int unsigned N  = 9;
  localparam int unsigned SW = 4;
  localparam int unsigned AW = 5;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          in_valid;
  logic          in_ready;
  logic [SW-1:0] sel;
  logic [N*W-1:0] data_in;
  logic [AW-1:0] wr_addr;
  logic          wr_en;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_data;
  logic [AW-1:0] out_addr;
  logic          out_wen;
  logic          out_err;
  logic          err_sticky;
  logic          err_clr;

  logic [W-1:0]  src [N];

  typedef struct packed {
    logic [31:0] data;
    logic [4:0]  addr;
    logic        wen;
    logic        err;
  } ent_t;

  ent_t        sb [$];
  int unsigned tests = 0;
  int unsigned fails = 0;
  logic        exp_sticky;
  logic        stall_pend;
  ent_t        stall_ent;

  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < int'(N); i++) data_in[i*W +: W] = src[i];
  end

  wb_src_select_pipe #(
    .WIDTH     (32),
    .NUM_SRC   (9),
    .SEL_W     (4),
    .ADDR_W    (5),
    .CONST_VAL (227)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .sel        (sel),
    .data_in    (data_in),
    .wr_addr    (wr_addr),
    .wr_en      (wr_en),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_addr   (out_addr),
    .out_wen    (out_wen),
    .out_err    (out_err),
    .err_sticky (err_sticky),
    .err_clr    (err_clr)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic ent_t model(input logic [3:0] s, input logic [4:0] a, input logic we);
    ent_t e;
    e.addr = a;
    e.err  = 1'b0;
    if (s < 4'd9)       e.data = src[s];
    else if (s == 4'd9) e.data = 32'd227;
    else begin
      e.data = 32'd0;
      e.err  = 1'b1;
    end
    e.wen = we && (a != 5'd0) && !e.err;
    return e;
  endfunction

  // Called at a falling edge; drives one cycle and checks the state visible before the next rising edge.
  task automatic step(input logic v, input logic [3:0] s, input logic [4:0] a,
                      input logic we, input logic ordy, input logic clr);
    ent_t e, o;
    in_valid  = v;
    sel       = s;
    wr_addr   = a;
    wr_en     = we;
    out_ready = ordy;
    err_clr   = clr;
    check("in_ready", 64'(in_ready), 64'(sb.size() < 2));
    check("out_valid", 64'(out_valid), 64'(sb.size() > 0));
    check("err_sticky", 64'(err_sticky), 64'(exp_sticky));
    o = {out_data, out_addr, out_wen, out_err};
    if (stall_pend) check("stall_stable", 64'(o), 64'(stall_ent));
    stall_pend = out_valid && !ordy;
    stall_ent  = o;
    if (out_valid && ordy && sb.size() > 0) begin
      e = sb.pop_front();
      check("out_data", 64'(out_data), 64'(e.data));
      check("out_addr", 64'(out_addr), 64'(e.addr));
      check("out_wen", 64'(out_wen), 64'(e.wen));
      check("out_err", 64'(out_err), 64'(e.err));
    end
    if (v && in_ready) begin
      e = model(s, a, we);
      sb.push_back(e);
      if (e.err) exp_sticky = 1'b1;
      else if (clr) exp_sticky = 1'b0;
    end else if (clr) begin
      exp_sticky = 1'b0;
    end
    @(negedge clk);
  endtask

  initial begin
    int unsigned pushed;
    logic        acc;
    logic        rv, rr, rc, rw;
    logic [3:0]  rs;
    logic [4:0]  ra;

    reset_n    = 1'b0;
    in_valid   = 1'b0;
    sel        = '0;
    wr_addr    = '0;
    wr_en      = 1'b0;
    out_ready  = 1'b0;
    err_clr    = 1'b0;
    exp_sticky = 1'b0;
    stall_pend = 1'b0;
    for (int i = 0; i < int'(N); i++) src[i] = 32'h1000 + i;

    repeat (2) @(negedge clk);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_data", 64'(out_data), 64'd0);
    check("rst_err_sticky", 64'(err_sticky), 64'd0);
    reset_n = 1'b1;

    // Source sweep with a free-running consumer.
    for (int i = 0; i < 9; i++) step(1'b1, 4'(i), 5'd3, 1'b1, 1'b1, 1'b0);
    step(1'b0, 4'd0, 5'd0, 1'b0, 1'b1, 1'b0);

    // Constant source, illegal selector, and clear racing a new illegal transfer.
    step(1'b1, 4'd9, 5'd3, 1'b1, 1'b1, 1'b0);
    step(1'b1, 4'd12, 5'd3, 1'b1, 1'b1, 1'b0);
    step(1'b0, 4'd0, 5'd0, 1'b0, 1'b1, 1'b0);
    step(1'b1, 4'd12, 5'd4, 1'b1, 1'b1, 1'b1);
    step(1'b0, 4'd0, 5'd0, 1'b0, 1'b1, 1'b1);
    step(1'b0, 4'd0, 5'd0, 1'b0, 1'b1, 1'b0);

    // Register 0 is never written but data still passes.
    step(1'b1, 4'd0, 5'd0, 1'b1, 1'b1, 1'b0);
    step(1'b0, 4'd0, 5'd0, 1'b0, 1'b1, 1'b0);

    // Backpressure: A and B fill the buffer, an illegal offer and C are held off.
    step(1'b1, 4'd1, 5'd7, 1'b1, 1'b0, 1'b0);
    step(1'b1, 4'd2, 5'd8, 1'b1, 1'b0, 1'b0);
    step(1'b1, 4'd15, 5'd9, 1'b1, 1'b0, 1'b0);
    step(1'b1, 4'd3, 5'd10, 1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 8; k++) begin
      acc = in_ready;
      step(1'b1, 4'd3, 5'd10, 1'b1, 1'b1, 1'b0);
      if (acc) break;
    end
    repeat (3) step(1'b0, 4'd0, 5'd0, 1'b0, 1'b1, 1'b0);
    check("bp_drained", 64'(sb.size()), 64'd0);

    // Random valid/ready traffic against the scoreboard.
    pushed = 0;
    for (int c = 0; c < 60000 && pushed < 10000; c++) begin
      for (int i = 0; i < int'(N); i++) src[i] = $urandom;
      rv = ($urandom_range(0, 9) < 7);
      rr = ($urandom_range(0, 9) < 6);
      rc = ($urandom_range(0, 15) == 0);
      rw = ($urandom_range(0, 3) != 0);
      rs = 4'($urandom_range(0, 15));
      ra = 5'($urandom_range(0, 31));
      if (rv && in_ready) pushed++;
      step(rv, rs, ra, rw, rr, rc);
    end
    check("rand_pushed", 64'(pushed), 64'd10000);
    repeat (4) step(1'b0, 4'd0, 5'd0, 1'b0, 1'b1, 1'b0);
    check("rand_drained", 64'(sb.size()), 64'd0);

    // Asynchronous reset with two entries buffered and the sticky flag set.
    step(1'b0, 4'd0, 5'd0, 1'b0, 1'b1, 1'b1);
    step(1'b1, 4'd13, 5'd1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 4'd2, 5'd5, 1'b1, 1'b0, 1'b0);
    check("pre_rst_sticky", 64'(err_sticky), 64'd1);
    #2;
    reset_n = 1'b0;
    #1;
    check("arst_out_valid", 64'(out_valid), 64'd0);
    check("arst_err_sticky", 64'(err_sticky), 64'd0);
    check("arst_out_data", 64'(out_data), 64'd0);
    check("arst_out_addr", 64'(out_addr), 64'd0);
    check("arst_out_wen", 64'(out_wen), 64'd0);
    check("arst_out_err", 64'(out_err), 64'd0);
    sb.delete();
    exp_sticky = 1'b0;
    stall_pend = 1'b0;
    in_valid   = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst_in_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    step(1'b1, 4'd4, 5'd6, 1'b1, 1'b1, 1'b0);
    step(1'b0, 4'd0, 5'd0, 1'b0, 1'b1, 1'b0);
    check("post_rst_drained", 64'(sb.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
